// File: rtl/icache_fetch_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// master = the cache itself; slave = the fetch stage plus controller port.
interface icache_fetch_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  in_req;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic                  in_flush;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_inst;
   logic [1:0]            mem_rw_flag;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [1:0]            mem_len;
   logic [DATA_WIDTH-1:0] mem_data_out;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic                  mem_busy;
   logic                  mem_done;

   modport master (
      input  in_req, in_addr, in_flush, mem_data_in, mem_busy, mem_done,
      output out_valid, out_inst, mem_rw_flag, mem_addr, mem_len, mem_data_out
   );

   modport slave (
      output in_req, in_addr, in_flush, mem_data_in, mem_busy, mem_done,
      input  out_valid, out_inst, mem_rw_flag, mem_addr, mem_len, mem_data_out
   );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache (one-word lines) with a single outstanding
// 4-byte read toward the memory controller; flushes abort in-flight returns.
module icache_fetch #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int INDEX_BITS = 7
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           rdy,
   icache_fetch_if.master bus
);
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

   state_t                state_r, state_next_s;
   logic [LINES-1:0]      valid_r;
   logic [TAG_BITS-1:0]   tag_r  [LINES];
   logic [DATA_WIDTH-1:0] data_r [LINES];
   logic [ADDR_WIDTH-1:0] lat_addr_r;
   logic                  abort_r, abort_next_s;
   logic                  out_valid_r, out_valid_next_s;
   logic [DATA_WIDTH-1:0] out_inst_r, out_inst_next_s;
   logic [1:0]            mem_rw_flag_r, mem_rw_flag_next_s;
   logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_next_s;
   logic [1:0]            mem_len_r, mem_len_next_s;

   logic [INDEX_BITS-1:0] in_idx_s, lat_idx_s;
   logic [TAG_BITS-1:0]   in_tag_s, lat_tag_s;
   logic                  accept_s, hit_s, issue_s, fill_s;

   assign in_idx_s  = bus.in_addr[INDEX_BITS+1:2];
   assign in_tag_s  = bus.in_addr[ADDR_WIDTH-1:INDEX_BITS+2];
   assign lat_idx_s = lat_addr_r[INDEX_BITS+1:2];
   assign lat_tag_s = lat_addr_r[ADDR_WIDTH-1:INDEX_BITS+2];

   // The out_valid term enforces the one-cycle bubble after every delivered word
   assign accept_s = (state_r == IDLE) && bus.in_req && !out_valid_r && !bus.in_flush;
   assign hit_s    = valid_r[in_idx_s] && (tag_r[in_idx_s] == in_tag_s);
   assign issue_s  = (state_r == ISSUE) && !bus.mem_busy && !bus.in_flush;
   assign fill_s   = (state_r == WAIT) && bus.mem_done && !bus.in_flush;

   assign bus.out_valid    = out_valid_r;
   assign bus.out_inst     = out_inst_r;
   assign bus.mem_rw_flag  = mem_rw_flag_r;
   assign bus.mem_addr     = mem_addr_r;
   assign bus.mem_len      = mem_len_r;
   assign bus.mem_data_out = {DATA_WIDTH{1'b0}};

   // Miss FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else if (rdy) begin
         state_r <= state_next_s;
      end
   end

   // Miss FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s && !hit_s) state_next_s = ISSUE;
            else                    state_next_s = IDLE;
         end
         ISSUE: begin
            if (bus.in_flush)       state_next_s = IDLE;
            else if (!bus.mem_busy) state_next_s = WAIT;
            else                    state_next_s = ISSUE;
         end
         WAIT: begin
            if (bus.mem_done) state_next_s = IDLE;
            else              state_next_s = WAIT;
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Next values of the registered outputs and the abort flag
   always_comb begin
      out_valid_next_s = 1'b0;
      out_inst_next_s  = out_inst_r;
      if (accept_s && hit_s) begin
         out_valid_next_s = 1'b1;
         out_inst_next_s  = data_r[in_idx_s];
      end else if (fill_s && !abort_r) begin
         out_valid_next_s = 1'b1;
         out_inst_next_s  = bus.mem_data_in;
      end else begin
         out_valid_next_s = 1'b0;
      end

      // Flag is only ever set from ISSUE, which WAIT always follows: a one-cycle pulse
      mem_addr_next_s = mem_addr_r;
      if (issue_s) begin
         mem_rw_flag_next_s = 2'b10;
         mem_addr_next_s    = lat_addr_r;
         mem_len_next_s     = 2'b11;
      end else begin
         mem_rw_flag_next_s = 2'b00;
         mem_len_next_s     = 2'b00;
      end

      abort_next_s = abort_r;
      if ((state_r == WAIT) && bus.mem_done) abort_next_s = 1'b0;
      else if ((state_r == WAIT) && bus.in_flush) abort_next_s = 1'b1;
      else abort_next_s = abort_r;
   end

   // Output, abort and miss-address registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_r   <= 1'b0;
         out_inst_r    <= {DATA_WIDTH{1'b0}};
         mem_rw_flag_r <= 2'b00;
         mem_addr_r    <= {ADDR_WIDTH{1'b0}};
         mem_len_r     <= 2'b00;
         abort_r       <= 1'b0;
         lat_addr_r    <= {ADDR_WIDTH{1'b0}};
      end else if (rdy) begin
         out_valid_r   <= out_valid_next_s;
         out_inst_r    <= out_inst_next_s;
         mem_rw_flag_r <= mem_rw_flag_next_s;
         mem_addr_r    <= mem_addr_next_s;
         mem_len_r     <= mem_len_next_s;
         abort_r       <= abort_next_s;
         if (accept_s && !hit_s) begin
            lat_addr_r <= bus.in_addr & ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};
         end
      end
   end

   // Line valid bits; flush wins over a coincident fill
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_r <= {LINES{1'b0}};
      end else if (rdy) begin
         if (bus.in_flush) valid_r <= {LINES{1'b0}};
         else if (fill_s)  valid_r[lat_idx_s] <= 1'b1;
      end
   end

   // Tag and data arrays, meaningful only behind a set valid bit
   always_ff @(posedge clk) begin
      if (rdy && fill_s) begin
         tag_r[lat_idx_s]  <= lat_tag_s;
         data_r[lat_idx_s] <= bus.mem_data_in;
      end
   end
endmodule
